// File: rtl/dtlb_pkg.sv
// dtlb shared definitions: PTE bit positions, privilege and satp encodings,
// FSM state type and small helpers used by the TLB and the page-table walker.
package dtlb_pkg;

    localparam int PTE_VALID   = 0;
    localparam int PTE_READ    = 1;
    localparam int PTE_WRITE   = 2;
    localparam int PTE_EXECUTE = 3;
    localparam int PTE_USER    = 4;
    localparam int PTE_ACCESS  = 6;
    localparam int PTE_DIRTY   = 7;

    localparam logic [1:0] MSTATUS_MPP_USER       = 2'b00;
    localparam logic [1:0] MSTATUS_MPP_SUPERVISOR = 2'b01;
    localparam logic [1:0] MSTATUS_MPP_MACHINE    = 2'b11;

    localparam logic [3:0] SATP_MODE_BARE = 4'd0;
    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

    localparam int TAG_W = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } dtlb_state_e;

    function automatic logic [63:0] pte_paddr(input logic [63:0] pte,
                                              input logic [11:0] off);
        return {8'b0, pte[53:10], off};
    endfunction

endpackage

// File: rtl/dtlb_if.sv
// dtlb client/walker bundle: lookup request/response plus the walk request
// and fill channel to the page-table walker.
interface dtlb_if;
    logic [63:0] req_vaddr;
    logic        req_valid;
    logic        req_is_store;
    logic        req_is_execute;
    logic        req_ready;
    logic [63:0] resp_paddr;
    logic        resp_page_fault;
    logic        resp_valid;
    logic [63:0] ptw_req_addr;
    logic        ptw_req_valid;
    logic        ptw_req_is_execute;
    logic        ptw_req_is_store;
    logic        ptw_fill;
    logic [26:0] ptw_fill_tag;
    logic [63:0] ptw_fill_pte;

    modport slave (
        input  req_vaddr, req_valid, req_is_store, req_is_execute,
        input  ptw_fill, ptw_fill_tag, ptw_fill_pte,
        output req_ready, resp_paddr, resp_page_fault, resp_valid,
        output ptw_req_addr, ptw_req_valid,
        output ptw_req_is_execute, ptw_req_is_store
    );

    modport master (
        output req_vaddr, req_valid, req_is_store, req_is_execute,
        output ptw_fill, ptw_fill_tag, ptw_fill_pte,
        input  req_ready, resp_paddr, resp_page_fault, resp_valid,
        input  ptw_req_addr, ptw_req_valid,
        input  ptw_req_is_execute, ptw_req_is_store
    );
endinterface

// File: rtl/dtlb_pte_perm_check.sv
// Leaf PTE permission check: PTE + access type + privilege -> fault.
// Shared by the data and instruction TLB instances.
module dtlb_pte_perm_check (
    input  logic [63:0] pte_i,
    input  logic        is_store_i,
    input  logic        is_execute_i,
    input  logic [1:0]  mpp_i,
    output logic        fault_o
);
    import dtlb_pkg::*;

    logic is_load;
    logic unused_bits;

    assign is_load     = !is_store_i && !is_execute_i;
    assign unused_bits = ^{pte_i[63:8], pte_i[5]};

    // Any single violated rule faults the access.
    always_comb begin
        fault_o = !pte_i[PTE_VALID]
               || (is_load && !pte_i[PTE_READ])
               || (is_store_i && !pte_i[PTE_WRITE])
               || (is_execute_i && !pte_i[PTE_EXECUTE])
               || !pte_i[PTE_ACCESS]
               || (is_store_i && !pte_i[PTE_DIRTY])
               || (mpp_i == MSTATUS_MPP_SUPERVISOR && pte_i[PTE_USER])
               || (mpp_i == MSTATUS_MPP_USER && !pte_i[PTE_USER]);
    end
endmodule

// File: rtl/dtlb.sv
// Fully-associative Sv39 TLB (4 KiB pages, no ASID) in front of the walker.
// Optional DTLB_PERF_EN adds saturating hit/miss counters.
module dtlb #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mpp,
    input  logic [63:0] satp,
    input  logic        sfence,
    dtlb_if.slave       bus
`ifdef DTLB_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    import dtlb_pkg::*;

    dtlb_state_e state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [63:0] resp_paddr_q;
    logic [63:0] ptw_addr_q;
    logic        ptw_valid_q;
    logic        ptw_store_q;
    logic        ptw_exec_q;
    logic [11:0] off_q;
    logic        store_q;
    logic        exec_q;
    logic        flushed_q;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [63:0]        pte_q [ENTRIES];
    logic [IDX_W-1:0]   repl_q;

    logic             accept;
    logic             bypass;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             fmatch;
    logic [IDX_W-1:0] fidx;
    logic [IDX_W-1:0] widx;
    logic             install;
    logic             in_miss;
    logic [63:0]      chk_pte;
    logic             chk_store;
    logic             chk_exec;
    logic [11:0]      chk_off;
    logic             chk_fault;
    logic [63:0]      chk_paddr;
    logic             unused_satp;

    assign unused_satp = ^satp[59:0];

    assign accept = state_q == ST_IDLE && bus.req_valid && req_ready_q;
    assign bypass = satp[63:60] == SATP_MODE_BARE
                 || mpp == MSTATUS_MPP_MACHINE;
    assign in_miss = state_q == ST_MISS;

    // Tag compare for the incoming lookup and for the fill tag.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        fmatch  = 1'b0;
        fidx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == bus.req_vaddr[38:12]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == bus.ptw_fill_tag) begin
                fmatch = 1'b1;
                fidx   = IDX_W'(i);
            end
        end
    end

    // One checker serves both the hit path and the fill path.
    assign chk_pte   = in_miss ? bus.ptw_fill_pte : pte_q[hit_idx];
    assign chk_store = in_miss ? store_q : bus.req_is_store;
    assign chk_exec  = in_miss ? exec_q : bus.req_is_execute;
    assign chk_off   = in_miss ? off_q : bus.req_vaddr[11:0];
    assign chk_paddr = chk_fault ? 64'd0 : pte_paddr(chk_pte, chk_off);

    dtlb_pte_perm_check u_chk (
        .pte_i        (chk_pte),
        .is_store_i   (chk_store),
        .is_execute_i (chk_exec),
        .mpp_i        (mpp),
        .fault_o      (chk_fault)
    );

    assign install = in_miss && bus.ptw_fill
                  && bus.ptw_fill_pte[PTE_VALID]
                  && !sfence && !flushed_q;
    assign widx = fmatch ? fidx : repl_q;

    // Lookup FSM with registered handshake, response and walk outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_paddr_q <= '0;
            ptw_valid_q  <= 1'b0;
            ptw_addr_q   <= '0;
            ptw_store_q  <= 1'b0;
            ptw_exec_q   <= 1'b0;
            off_q        <= '0;
            store_q      <= 1'b0;
            exec_q       <= 1'b0;
            flushed_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        off_q       <= bus.req_vaddr[11:0];
                        store_q     <= bus.req_is_store;
                        exec_q      <= bus.req_is_execute;
                        flushed_q   <= 1'b0;
                        if (bypass) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_paddr_q <= bus.req_vaddr;
                            resp_fault_q <= 1'b0;
                        end else if (hit) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_paddr_q <= chk_paddr;
                            resp_fault_q <= chk_fault;
                        end else begin
                            state_q     <= ST_MISS;
                            ptw_valid_q <= 1'b1;
                            ptw_addr_q  <= bus.req_vaddr;
                            ptw_store_q <= bus.req_is_store;
                            ptw_exec_q  <= bus.req_is_execute;
                        end
                    end
                end
                ST_MISS: begin
                    if (sfence) begin
                        flushed_q <= 1'b1;
                    end
                    if (bus.ptw_fill) begin
                        ptw_valid_q  <= 1'b0;
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_paddr_q <= chk_paddr;
                        resp_fault_q <= chk_fault;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid bits and replacement pointer; sfence wins over a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            repl_q  <= '0;
        end else begin
            if (sfence) begin
                valid_q <= '0;
            end else if (install) begin
                valid_q[widx] <= 1'b1;
            end
            if (install && !fmatch) begin
                repl_q <= repl_q + 1'b1;
            end
        end
    end

    // Entry payload needs no reset: it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[widx] <= bus.ptw_fill_tag;
            pte_q[widx] <= bus.ptw_fill_pte;
        end
    end

`ifdef DTLB_PERF_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    // Saturating counters for translated (non-bypass) lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (accept && !bypass) begin
            if (hit && hits_q != 32'hFFFF_FFFF) begin
                hits_q <= hits_q + 32'd1;
            end
            if (!hit && misses_q != 32'hFFFF_FFFF) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif

    assign bus.req_ready          = req_ready_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_paddr         = resp_paddr_q;
    assign bus.resp_page_fault    = resp_fault_q;
    assign bus.ptw_req_valid      = ptw_valid_q;
    assign bus.ptw_req_addr       = ptw_addr_q;
    assign bus.ptw_req_is_store   = ptw_store_q;
    assign bus.ptw_req_is_execute = ptw_exec_q;
endmodule

// File: tb/tb_dtlb.sv
// Directed bench for dtlb: bypass, miss/fill, hit, permission faults,
// invalid fill, sfence during a walk and replacement wrap.
module tb_dtlb;
    localparam logic [63:0] SV39  = {4'd8, 60'd0};
    localparam logic [1:0]  MPP_U = 2'b00;
    localparam logic [1:0]  MPP_S = 2'b01;
    localparam logic [1:0]  MPP_M = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  mpp;
    logic [63:0] satp;
    logic        sfence;
    int          vec;
    int          err;

    dtlb_if bus ();

    dtlb #(.ENTRIES(8), .IDX_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .mpp    (mpp),
        .satp   (satp),
        .sfence (sfence),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        vec++;
        assert (got === exp) else begin
            err++;
            $error("FAIL %s: observed %h expected %h", nm, got, exp);
        end
    endtask

    task automatic lookup(input string nm, input logic [63:0] va,
                          input logic st, input logic ex,
                          input logic miss, input logic [63:0] pte,
                          input logic flush, input logic [63:0] ep,
                          input logic ef);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_vaddr      = va;
        bus.req_is_store   = st;
        bus.req_is_execute = ex;
        bus.req_valid      = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({nm, " walk"}, 64'(bus.ptw_req_valid), 64'(miss));
        if (miss) begin
            chk({nm, " walk addr"}, bus.ptw_req_addr, va);
            chk({nm, " no early resp"}, 64'(bus.resp_valid), 64'd0);
            if (flush) begin
                sfence = 1'b1;
                @(negedge clk);
                sfence = 1'b0;
                chk({nm, " walk held"}, 64'(bus.ptw_req_valid), 64'd1);
            end
            bus.ptw_fill     = 1'b1;
            bus.ptw_fill_tag = va[38:12];
            bus.ptw_fill_pte = pte;
            @(negedge clk);
            bus.ptw_fill = 1'b0;
            chk({nm, " walk drop"}, 64'(bus.ptw_req_valid), 64'd0);
        end
        chk({nm, " resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({nm, " paddr"}, bus.resp_paddr, ep);
        chk({nm, " fault"}, 64'(bus.resp_page_fault), 64'(ef));
        @(negedge clk);
        chk({nm, " pulse"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] va;
        logic [63:0] pte;
        logic [63:0] pa;
        vec  = 0;
        err  = 0;
        rst  = 1'b1;
        mpp  = MPP_S;
        satp = 64'd0;
        sfence = 1'b0;
        bus.req_vaddr      = '0;
        bus.req_valid      = 1'b0;
        bus.req_is_store   = 1'b0;
        bus.req_is_execute = 1'b0;
        bus.ptw_fill       = 1'b0;
        bus.ptw_fill_tag   = '0;
        bus.ptw_fill_pte   = '0;

        repeat (3) @(negedge clk);
        chk("rst ready", 64'(bus.req_ready), 64'd0);
        chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst fault", 64'(bus.resp_page_fault), 64'd0);
        chk("rst paddr", bus.resp_paddr, 64'd0);
        chk("rst walk", 64'(bus.ptw_req_valid), 64'd0);
        chk("rst walk addr", bus.ptw_req_addr, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle ready", 64'(bus.req_ready), 64'd1);

        lookup("bare", 64'h8000_1234, 0, 0, 0, 0, 0,
               64'h8000_1234, 0);
        satp = SV39;
        mpp  = MPP_M;
        lookup("mach", 64'h1234_5678, 1, 0, 0, 0, 0,
               64'h1234_5678, 0);
        mpp = MPP_S;

        lookup("cold", 64'h0040_3ABC, 0, 0, 1, 64'h2000_00C7, 0,
               64'h8000_0ABC, 0);
        lookup("rehit", 64'h0040_3123, 0, 0, 0, 0, 0,
               64'h8000_0123, 0);

        lookup("clean ld", 64'h0050_0010, 0, 0, 1, 64'h2000_0447, 0,
               64'h8000_1010, 0);
        lookup("clean st", 64'h0050_0020, 1, 0, 0, 0, 0,
               64'd0, 1);
        lookup("clean ld2", 64'h0050_0030, 0, 0, 0, 0, 0,
               64'h8000_1030, 0);

        lookup("pte0", 64'h0060_0040, 0, 0, 1, 64'd0, 0, 64'd0, 1);
        lookup("pte0 again", 64'h0060_0040, 0, 0, 1, 64'd0, 0,
               64'd0, 1);

        lookup("flush walk", 64'h0070_0008, 0, 0, 1, 64'h2000_08C7, 1,
               64'h8000_2008, 0);
        lookup("flush refill", 64'h0070_0010, 0, 0, 1, 64'h2000_08C7, 0,
               64'h8000_2010, 0);
        lookup("flush old1", 64'h0040_3ABC, 0, 0, 1, 64'h2000_00C7, 0,
               64'h8000_0ABC, 0);
        lookup("flush old2", 64'h0050_0010, 0, 0, 1, 64'h2000_0447, 0,
               64'h8000_1010, 0);

        sfence = 1'b1;
        @(negedge clk);
        sfence = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            va  = 64'h1000_0000 + 64'(i) * 64'h1000 + 64'(i) * 8;
            pte = ((64'h90000 + 64'(i)) << 10) | 64'hC7;
            pa  = ((64'h90000 + 64'(i)) << 12) | (64'(i) * 8);
            lookup($sformatf("fill%0d", i), va, 0, 0, 1, pte, 0, pa, 0);
        end
        for (int i = 2; i <= 9; i++) begin
            va = 64'h1000_0000 + 64'(i) * 64'h1000 + 64'h100;
            pa = ((64'h90000 + 64'(i)) << 12) | 64'h100;
            lookup($sformatf("hit%0d", i), va, 0, 0, 0, 0, 0, pa, 0);
        end
        lookup("exec nox", 64'h1000_2000, 0, 1, 0, 0, 0, 64'd0, 1);
        mpp = MPP_U;
        lookup("user s-page", 64'h1000_9000, 0, 0, 0, 0, 0, 64'd0, 1);
        mpp = MPP_S;
        lookup("evicted", 64'h1000_1000, 0, 0, 1, 64'h2400_04C7, 0,
               64'h9000_1000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
